// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard
// detection folded in. Decoded operands, the sign-extended immediate, register
// indices and control bits are captured at the end of ID and presented to EX
// one cycle later. Bubbles are inserted on a branch flush or a load-use hazard.
// The whole register freezes on a downstream hold. A saturating counter tracks
// how many load-use bubbles have been inserted.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   hold                    downstream freeze; register keeps its contents
//   flush                   branch taken; the instruction in ID is discarded
//   id_valid                ID holds a real instruction
//   read_data_1/2, ins_15_0 ID operands and sign-extended immediate (DATA_W)
//   rs, rt, rd              ID register fields
//   reg_write .. branch     ID control bits
//   alu_op                  ID ALU op (000 add, 001 sub, 010 R-type, 011 I-type)
//   ID_EX_*                 registered copies of the above, plus ID_EX_valid
//   pc_write, if_id_write   combinational; 0 freezes PC and IF/ID
//   stall_cycles            load-use bubbles inserted, saturating
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] ins_15_0,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              branch,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] ID_EX_read_data_1,
    output logic [DATA_W-1:0] ID_EX_read_data_2,
    output logic [DATA_W-1:0] ID_EX_ins_15_0,
    output logic [4:0]        ID_EX_rs,
    output logic [4:0]        ID_EX_rt,
    output logic [4:0]        ID_EX_rd,
    output logic              ID_EX_reg_write,
    output logic              ID_EX_mem_to_reg,
    output logic              ID_EX_mem_read,
    output logic              ID_EX_mem_write,
    output logic              ID_EX_alu_src,
    output logic              ID_EX_reg_dst,
    output logic              ID_EX_branch,
    output logic [2:0]        ID_EX_alu_op,
    output logic              ID_EX_valid,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned REG_W    = 5;
    localparam int unsigned ALU_OP_W = 3;

    // Control bits squashed to zero on a bubble.
    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src;
        logic                reg_dst;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // Operands and indices; captured even on a bubble so they stay deterministic.
    typedef struct packed {
        logic [DATA_W-1:0] read_data_1;
        logic [DATA_W-1:0] read_data_2;
        logic [DATA_W-1:0] ins_15_0;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } data_t;

    // What the register does at the next edge (reset handled in the flop block).
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_STALL = 2'd3
    } act_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_t            ctrl_q, ctrl_d, ctrl_in;
    data_t            data_q, data_d, data_in;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             luh;
    logic             rt_match;
    act_e             act;

    // Bundle the ID-stage inputs.
    always_comb begin
        ctrl_in.reg_write  = reg_write;
        ctrl_in.mem_to_reg = mem_to_reg;
        ctrl_in.mem_read   = mem_read;
        ctrl_in.mem_write  = mem_write;
        ctrl_in.alu_src    = alu_src;
        ctrl_in.reg_dst    = reg_dst;
        ctrl_in.branch     = branch;
        ctrl_in.alu_op     = alu_op;

        data_in.read_data_1 = read_data_1;
        data_in.read_data_2 = read_data_2;
        data_in.ins_15_0    = ins_15_0;
        data_in.rs          = rs;
        data_in.rt          = rt;
        data_in.rd          = rd;
    end

    // Load-use hazard: load in EX writes a non-zero register that ID reads.
    // Both rs and rt are compared regardless of opcode (conservative).
    always_comb begin
        rt_match = (data_q.rt == rs) || (data_q.rt == rt);
        luh      = valid_q && ctrl_q.mem_read && (data_q.rt != REG_W'(0))
                   && id_valid && rt_match;
    end

    assign pc_write    = ~(luh | hold);
    assign if_id_write = ~(luh | hold);

    // Update priority below reset: hold, flush, load-use, load.
    always_comb begin
        act = ACT_LOAD;
        if (hold) begin
            act = ACT_HOLD;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (luh) begin
            act = ACT_STALL;
        end
    end

    // Next register contents for each action.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (act)
            ACT_HOLD: begin
                valid_d = valid_q;
            end
            ACT_FLUSH: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                data_d  = data_in;
            end
            ACT_STALL: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                data_d  = data_in;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
            default: begin
                // Controls are taken as presented even when id_valid is low.
                valid_d = id_valid;
                ctrl_d  = ctrl_in;
                data_d  = data_in;
            end
        endcase
    end

    // Pipeline register and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ID_EX_read_data_1 = data_q.read_data_1;
    assign ID_EX_read_data_2 = data_q.read_data_2;
    assign ID_EX_ins_15_0    = data_q.ins_15_0;
    assign ID_EX_rs          = data_q.rs;
    assign ID_EX_rt          = data_q.rt;
    assign ID_EX_rd          = data_q.rd;
    assign ID_EX_reg_write   = ctrl_q.reg_write;
    assign ID_EX_mem_to_reg  = ctrl_q.mem_to_reg;
    assign ID_EX_mem_read    = ctrl_q.mem_read;
    assign ID_EX_mem_write   = ctrl_q.mem_write;
    assign ID_EX_alu_src     = ctrl_q.alu_src;
    assign ID_EX_reg_dst     = ctrl_q.reg_dst;
    assign ID_EX_branch      = ctrl_q.branch;
    assign ID_EX_alu_op      = ctrl_q.alu_op;
    assign ID_EX_valid       = valid_q;
    assign stall_cycles      = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a small behavioural model predicts the register
// contents after each edge; predictions are queued when inputs are driven and
// popped once the edge has happened.
module tb_id_ex_pipe_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    typedef struct packed {
        logic        reset;
        logic        hold;
        logic        flush;
        logic        id_valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic [2:0]  alu_op;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic [2:0]  alu_op;
        logic [1:0]  stall;
    } st_t;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [31:0] read_data_1, read_data_2, ins_15_0;
    logic [4:0]  rs, rt, rd;
    logic        reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, branch;
    logic [2:0]  alu_op;
    logic [31:0] ID_EX_read_data_1, ID_EX_read_data_2, ID_EX_ins_15_0;
    logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_rd;
    logic        ID_EX_reg_write, ID_EX_mem_to_reg, ID_EX_mem_read, ID_EX_mem_write;
    logic        ID_EX_alu_src, ID_EX_reg_dst, ID_EX_branch, ID_EX_valid;
    logic [2:0]  ID_EX_alu_op;
    logic        pc_write, if_id_write;
    logic [1:0]  stall_cycles;

    int   checks   = 0;
    int   failures = 0;
    st_t  m = '0;
    st_t  sb[$];
    logic exp_pcw;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .read_data_1(read_data_1), .read_data_2(read_data_2), .ins_15_0(ins_15_0),
        .rs(rs), .rt(rt), .rd(rd),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch),
        .alu_op(alu_op),
        .ID_EX_read_data_1(ID_EX_read_data_1), .ID_EX_read_data_2(ID_EX_read_data_2),
        .ID_EX_ins_15_0(ID_EX_ins_15_0),
        .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd),
        .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_to_reg(ID_EX_mem_to_reg),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
        .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_reg_dst(ID_EX_reg_dst),
        .ID_EX_branch(ID_EX_branch), .ID_EX_alu_op(ID_EX_alu_op),
        .ID_EX_valid(ID_EX_valid),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cycles(stall_cycles)
    );

    // Reference behaviour of the register.
    function automatic logic model_luh(st_t s, in_t i);
        return s.valid && s.mem_read && (s.rt != 5'd0) && i.id_valid &&
               ((s.rt == i.rs) || (s.rt == i.rt));
    endfunction

    function automatic st_t model_next(st_t s, in_t i);
        st_t n;
        logic h;
        n = s;
        h = model_luh(s, i);
        if (i.reset) begin
            n = '0;
        end else if (!i.hold) begin
            n.rd1 = i.rd1; n.rd2 = i.rd2; n.imm = i.imm;
            n.rs  = i.rs;  n.rt  = i.rt;  n.rd  = i.rd;
            if (i.flush || h) begin
                n.valid = 1'b0; n.reg_write = 1'b0; n.mem_to_reg = 1'b0;
                n.mem_read = 1'b0; n.mem_write = 1'b0; n.alu_src = 1'b0;
                n.reg_dst = 1'b0; n.branch = 1'b0; n.alu_op = 3'b000;
                if (!i.flush && s.stall != 2'b11) n.stall = s.stall + 2'd1;
            end else begin
                n.valid = i.id_valid; n.reg_write = i.reg_write;
                n.mem_to_reg = i.mem_to_reg; n.mem_read = i.mem_read;
                n.mem_write = i.mem_write; n.alu_src = i.alu_src;
                n.reg_dst = i.reg_dst; n.branch = i.branch; n.alu_op = i.alu_op;
            end
        end
        return n;
    endfunction

    function automatic st_t sample();
        st_t o;
        o.valid = ID_EX_valid; o.rd1 = ID_EX_read_data_1; o.rd2 = ID_EX_read_data_2;
        o.imm = ID_EX_ins_15_0; o.rs = ID_EX_rs; o.rt = ID_EX_rt; o.rd = ID_EX_rd;
        o.reg_write = ID_EX_reg_write; o.mem_to_reg = ID_EX_mem_to_reg;
        o.mem_read = ID_EX_mem_read; o.mem_write = ID_EX_mem_write;
        o.alu_src = ID_EX_alu_src; o.reg_dst = ID_EX_reg_dst; o.branch = ID_EX_branch;
        o.alu_op = ID_EX_alu_op; o.stall = stall_cycles;
        return o;
    endfunction

    function automatic in_t mk_nop();
        in_t i = '0;
        return i;
    endfunction

    function automatic in_t mk_lw(logic [4:0] s, logic [4:0] t);
        in_t i = '0;
        i.id_valid = 1'b1; i.rs = s; i.rt = t; i.imm = 32'h0000_0010;
        i.rd1 = 32'h0000_1000; i.mem_read = 1'b1; i.mem_to_reg = 1'b1;
        i.reg_write = 1'b1; i.alu_src = 1'b1; i.alu_op = 3'b000;
        return i;
    endfunction

    function automatic in_t mk_add(logic [4:0] s, logic [4:0] t, logic [4:0] d);
        in_t i = '0;
        i.id_valid = 1'b1; i.rs = s; i.rt = t; i.rd = d;
        i.rd1 = 32'hA5A5_0001; i.rd2 = 32'h0000_0022;
        i.reg_write = 1'b1; i.reg_dst = 1'b1; i.alu_op = 3'b010;
        return i;
    endfunction

    // Drive one cycle's ID inputs and queue the predicted post-edge state.
    task automatic apply(input in_t i);
        reset = i.reset; hold = i.hold; flush = i.flush; id_valid = i.id_valid;
        read_data_1 = i.rd1; read_data_2 = i.rd2; ins_15_0 = i.imm;
        rs = i.rs; rt = i.rt; rd = i.rd;
        reg_write = i.reg_write; mem_to_reg = i.mem_to_reg; mem_read = i.mem_read;
        mem_write = i.mem_write; alu_src = i.alu_src; reg_dst = i.reg_dst;
        branch = i.branch; alu_op = i.alu_op;
        exp_pcw = !(model_luh(m, i) || i.hold);
        m = model_next(m, i);
        sb.push_back(m);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_t i;
        st_t e, o;
        i = '1;
        apply(i);
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset_state got=%h want=%h", o, e); end
        checks++;
        if (o !== st_t'(0)) begin failures++; $display("FAIL reset_zero got=%h want=0", o); end
        apply(mk_nop());
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            failures++; $display("FAIL reset_pc_write got=%b/%b want=1/1", pc_write, if_id_write);
        end
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset_nop got=%h want=%h", o, e); end
    endtask

    task automatic test_reg0();
        st_t e, o;
        apply(mk_lw(5'd2, 5'd0));
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL reg0_lw got=%h want=%h", o, e); end
        apply(mk_add(5'd0, 5'd0, 5'd3));
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            failures++; $display("FAIL reg0_no_stall got=%b/%b want=1/1", pc_write, if_id_write);
        end
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL reg0_add got=%h want=%h", o, e); end
        checks++;
        if (o.stall !== 2'd0 || o.valid !== 1'b1) begin
            failures++; $display("FAIL reg0_counter got=%0d/%b want=0/1", o.stall, o.valid);
        end
    endtask

    task automatic test_pass_through();
        in_t i;
        st_t e, o;
        i = '0;
        i.id_valid = 1'b1; i.rd1 = 32'h0000_1234; i.imm = 32'hFFFF_FFF0;
        i.alu_op = 3'b010; i.reg_write = 1'b1; i.rd = 5'd5;
        apply(i);
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL pass_model got=%h want=%h", o, e); end
        checks++;
        if (o.rd1 !== 32'h0000_1234 || o.imm !== 32'hFFFF_FFF0 || o.alu_op !== 3'b010 ||
            o.reg_write !== 1'b1 || o.rd !== 5'd5 || o.valid !== 1'b1) begin
            failures++; $display("FAIL pass_fields got=%h", o);
        end
    endtask

    task automatic test_load_use();
        st_t e, o;
        apply(mk_lw(5'd3, 5'd8));
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL lu_lw got=%h want=%h", o, e); end
        apply(mk_add(5'd8, 5'd9, 5'd10));
        checks++;
        if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
            failures++; $display("FAIL lu_freeze got=%b/%b want=0/0", pc_write, if_id_write);
        end
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL lu_bubble got=%h want=%h", o, e); end
        checks++;
        if (o.valid !== 1'b0 || o.reg_write !== 1'b0 || o.stall !== 2'd1) begin
            failures++; $display("FAIL lu_bubble_fields got=%b/%b/%0d want=0/0/1",
                                 o.valid, o.reg_write, o.stall);
        end
        apply(mk_add(5'd8, 5'd9, 5'd10));
        checks++;
        if (pc_write !== 1'b1) begin failures++; $display("FAIL lu_release got=%b want=1", pc_write); end
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e || o.rs !== 5'd8 || o.valid !== 1'b1) begin
            failures++; $display("FAIL lu_add got=%h want=%h", o, e);
        end
    endtask

    task automatic test_flush_luh_hold();
        in_t i;
        st_t e, o, frozen;
        logic [1:0] cnt_before;
        apply(mk_lw(5'd1, 5'd7));
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL fl_lw got=%h want=%h", o, e); end
        cnt_before = m.stall;
        i = mk_add(5'd7, 5'd2, 5'd4);
        i.flush = 1'b1;
        apply(i);
        checks++;
        if (pc_write !== 1'b0) begin failures++; $display("FAIL fl_luh_pcw got=%b want=0", pc_write); end
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e || o.valid !== 1'b0 || o.stall !== cnt_before) begin
            failures++; $display("FAIL fl_bubble got=%h want=%h", o, e);
        end
        apply(mk_add(5'd11, 5'd12, 5'd13));
        tick();
        e = sb.pop_front(); o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL fl_reload got=%h want=%h", o, e); end
        frozen = m;
        for (int k = 0; k < 3; k++) begin
            i = mk_lw(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            i.rd1 = $urandom; i.imm = $urandom; i.hold = 1'b1; i.flush = k[0];
            apply(i);
            checks++;
            if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
                failures++; $display("FAIL hold_pcw[%0d] got=%b/%b want=0/0", k, pc_write, if_id_write);
            end
            tick();
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e || o !== frozen) begin
                failures++; $display("FAIL hold_frozen[%0d] got=%h want=%h", k, o, frozen);
            end
        end
    endtask

    task automatic test_saturation();
        st_t e, o;
        for (int k = 0; k < 5; k++) begin
            apply(mk_lw(5'd1, 5'd6));
            tick();
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin failures++; $display("FAIL sat_lw[%0d] got=%h want=%h", k, o, e); end
            apply(mk_add(5'd6, 5'd2, 5'd3));
            tick();
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin failures++; $display("FAIL sat_bubble[%0d] got=%h want=%h", k, o, e); end
        end
        checks++;
        if (stall_cycles !== 2'b11) begin
            failures++; $display("FAIL sat_value got=%0d want=3", stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        in_t i;
        in_t seq[3];
        st_t e, o;
        seq[0] = mk_lw(5'd1, 5'd4);
        seq[1] = mk_add(5'd1, 5'd2, 5'd3);
        seq[2] = mk_add(5'd4, 5'd5, 5'd6);
        for (int k = 0; k < 3; k++) begin
            apply(seq[k]);
            checks++;
            if (pc_write !== 1'b1) begin failures++; $display("FAIL b2b_no_stall[%0d] got=%b want=1", k, pc_write); end
            tick();
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin failures++; $display("FAIL b2b_seq[%0d] got=%h want=%h", k, o, e); end
        end
        for (int k = 0; k < 250; k++) begin
            i = '0;
            i.reset = ($urandom_range(0, 99) < 3);
            i.hold  = ($urandom_range(0, 99) < 25);
            i.flush = ($urandom_range(0, 99) < 15);
            i.id_valid = ($urandom_range(0, 99) < 85);
            i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom;
            i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3));
            i.rd = 5'($urandom_range(0, 31));
            i.mem_read = $urandom_range(0, 1); i.reg_write = $urandom_range(0, 1);
            i.mem_to_reg = $urandom_range(0, 1); i.mem_write = $urandom_range(0, 1);
            i.alu_src = $urandom_range(0, 1); i.reg_dst = $urandom_range(0, 1);
            i.branch = $urandom_range(0, 1); i.alu_op = 3'($urandom_range(0, 7));
            apply(i);
            checks++;
            if (pc_write !== exp_pcw || if_id_write !== exp_pcw) begin
                failures++; $display("FAIL rand_pcw[%0d] got=%b/%b want=%b", k, pc_write, if_id_write, exp_pcw);
            end
            tick();
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin failures++; $display("FAIL rand_state[%0d] got=%h want=%h", k, o, e); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        apply(mk_nop());
        void'(sb.pop_front());
        tick();
        test_reset();
        test_reg0();
        test_pass_through();
        test_load_use();
        test_flush_luh_hold();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
